instruction_fetch_unit: RTL and testbench

- Front stage of the processor. Owns the fetch PC and requests 32-bit instruction words from a variable-latency instruction memory.
- Presents each returned word with its PC to the decode/control stage over a valid/ack handshake.
- Accepts branch/jump redirects from downstream and squashes any fetch that is in flight when the redirect arrives.

---
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Front stage of the processor. Owns the fetch PC, issues single
//   outstanding reads to a variable-latency instruction memory, and
//   presents each returned word with its PC over a valid/ack handshake.
//   Downstream redirects reload the PC and squash any in-flight fetch.
//
// Build option:
//   FETCH_COUNT_EN  when defined, fetch_count counts delivered instructions
//                   (valid && ack without redirect); otherwise tied to 0.
//
// Ports:
//   clk, clr_n                   clock, asynchronous active-low reset
//   redirect, redirect_addr      load PC from target, squash current fetch
//   imem_req, imem_addr          memory read request / word address
//   imem_ready, imem_rdata       memory completion / returned word
//   instr_valid, instr, instr_pc registered instruction to decode
//   instr_ack                    downstream consumes instr this cycle
//   fetch_count                  delivered-instruction counter
module instruction_fetch_unit #(
  parameter int unsigned            ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ack,
  output logic [31:0]       fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_d;
  logic [31:0]       instr_d;
  logic [ADDR_W-1:0] instr_pc_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      instr_valid <= valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    valid_d    = instr_valid;
    instr_d    = instr;
    instr_pc_d = instr_pc;

    case (state)
      S_IDLE: state_d = S_REQ;

      S_REQ, S_WAIT: begin
        if (redirect) begin
          // A word returning in the redirect cycle is simply dropped; only
          // an unanswered request leaves an orphan that must be drained.
          state_d = imem_ready ? S_REQ : S_DRAIN;
        end else if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc;
          valid_d    = 1'b1;
          pc_d       = pc + ADDR_W'(1);
          state_d    = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_HOLD: begin
        if (redirect || instr_ack) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end

      S_DRAIN: if (imem_ready) state_d = S_REQ;

      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      pc_d    = redirect_addr;
      valid_d = 1'b0;
    end

    // Request outputs are registered, so they are derived from the state
    // being entered; a fresh S_REQ always presents the updated PC.
    req_d  = (state_d == S_REQ) || (state_d == S_WAIT);
    addr_d = (state_d == S_REQ) ? pc_d : imem_addr;
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] count_q;
  logic        count_inc;

  assign count_inc = (state == S_HOLD) && instr_ack && !redirect;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)         count_q <= '0;
    else if (count_inc) count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_addr = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ack = 1'b0;
  logic [31:0] fetch_count;

`ifdef FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  logic [31:0] mem [256];
  int unsigned mem_wait = 0;
  bit          mem_rand = 1'b0;
  bit          busy = 1'b0;
  int unsigned cnt = 0;
  logic [7:0]  baddr = '0;
  int          proto_err = 0;

  instruction_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .clr_n(clr_n), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ack(instr_ack), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Variable-latency memory: one outstanding request, completes after
  // a wait of mem_wait (or random 0..3) cycles, even if req is withdrawn.
  always @(negedge clk) begin
    if (!clr_n) begin
      busy = 1'b0;
      imem_ready = 1'b0;
    end else begin
      if (imem_ready) begin
        imem_ready = 1'b0;
        busy = 1'b0;
      end
      if (busy && imem_req && imem_addr !== baddr) proto_err++;
      if (!busy && imem_req) begin
        busy  = 1'b1;
        baddr = imem_addr;
        cnt   = mem_rand ? $urandom_range(0, 3) : mem_wait;
      end
      if (busy) begin
        if (cnt == 0) begin
          imem_ready = 1'b1;
          imem_rdata = mem[baddr];
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic do_reset(input logic [7:0] ra, input bit rd);
    clr_n = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    redirect = rd;
    redirect_addr = ra;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req); end
    n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %h exp 00", imem_addr); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
    n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h exp 0", instr); end
    n_tests++; if (instr_pc !== 8'h00) begin n_fail++; $display("FAIL rst_pc: got %h exp 00", instr_pc); end
    n_tests++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", fetch_count); end
  endtask

  task automatic test_zero_wait;
    mem_rand = 1'b0; mem_wait = 0;
    mem[0] = 32'h20080005;
    instr_ack = 1'b1;
    do_reset(8'h00, 1'b0);
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req: got %b exp 1", imem_req); end
    n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL zw_addr0: got %h exp 00", imem_addr); end
    @(negedge clk);
    n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid: got %b exp 1", instr_valid); end
    n_tests++; if (instr !== 32'h20080005) begin n_fail++; $display("FAIL zw_instr: got %h exp 20080005", instr); end
    n_tests++; if (instr_pc !== 8'h00) begin n_fail++; $display("FAIL zw_pc: got %h exp 00", instr_pc); end
    @(negedge clk);
    n_tests++; if (imem_addr !== 8'h01 || imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_addr1: got req %b addr %h exp req 1 addr 01", imem_req, imem_addr); end
  endtask

  task automatic test_latency_stall;
    int req_cycles = 0;
    int addr_bad = 0;
    int stall_bad = 0;
    bit got = 1'b0;
    mem_rand = 1'b0; mem_wait = 2;
    mem[0] = 32'hAABBCCDD;
    instr_ack = 1'b0;
    do_reset(8'h00, 1'b0);
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (instr_valid) got = 1'b1;
      else if (imem_req) begin
        req_cycles++;
        if (imem_addr !== 8'h00) addr_bad++;
      end
    end
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL lat_timeout: got valid %b exp 1", got); end
    n_tests++; if (req_cycles != 3) begin n_fail++; $display("FAIL lat_req_cycles: got %0d exp 3", req_cycles); end
    n_tests++; if (addr_bad != 0) begin n_fail++; $display("FAIL lat_addr_stable: got %0d changes exp 0", addr_bad); end
    n_tests++; if (instr !== 32'hAABBCCDD) begin n_fail++; $display("FAIL lat_instr: got %h exp aabbccdd", instr); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(instr_valid === 1'b1 && instr === 32'hAABBCCDD && instr_pc === 8'h00 && imem_req === 1'b0))
        stall_bad++;
    end
    n_tests++; if (stall_bad != 0) begin n_fail++; $display("FAIL hold_stable: got %0d bad cycles exp 0", stall_bad); end
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ack_valid: got %b exp 0", instr_valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin n_fail++; $display("FAIL hold_next_req: got req %b addr %h exp req 1 addr 01", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_drain;
    bit seen_bad = 1'b0;
    bit have_addr = 1'b0;
    logic [7:0] first_addr = 8'hxx;
    mem_rand = 1'b0; mem_wait = 3;
    mem[8'h00] = 32'hDEADBEEF;
    mem[8'h40] = 32'h11223344;
    instr_ack = 1'b0;
    do_reset(8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL drn_wait_req: got %b exp 1", imem_req); end
    redirect = 1'b1; redirect_addr = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drn_req_low: got %b exp 0", imem_req); end
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      @(negedge clk);
      if (instr_valid && instr === 32'hDEADBEEF) seen_bad = 1'b1;
      if (imem_req && !have_addr) begin have_addr = 1'b1; first_addr = imem_addr; end
    end
    n_tests++; if (seen_bad !== 1'b0) begin n_fail++; $display("FAIL drn_orphan_seen: got %b exp 0", seen_bad); end
    n_tests++; if (first_addr !== 8'h40) begin n_fail++; $display("FAIL drn_next_addr: got %h exp 40", first_addr); end
    n_tests++; if (instr_valid !== 1'b1 || instr !== 32'h11223344 || instr_pc !== 8'h40) begin
      n_fail++; $display("FAIL drn_target_instr: got v%b %h @%h exp v1 11223344 @40", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_wrap_redirect_ack;
    logic [31:0] w_ff;
    logic [31:0] w_00;
    w_ff = $urandom; w_00 = $urandom;
    mem[8'hFF] = w_ff; mem[8'h00] = w_00;
    mem_rand = 1'b0; mem_wait = 0;
    instr_ack = 1'b1;
    do_reset(8'hFF, 1'b1);
    @(negedge clk);
    redirect = 1'b0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_idle_redirect: got req %b addr %h exp req 1 addr ff", imem_req, imem_addr); end
    @(negedge clk);
    n_tests++; if (instr_valid !== 1'b1 || instr !== w_ff || instr_pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_instr_ff: got v%b %h @%h exp v1 %h @ff", instr_valid, instr, instr_pc, w_ff); end
    @(negedge clk);
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_addr: got req %b addr %h exp req 1 addr 00", imem_req, imem_addr); end
    @(negedge clk);
    n_tests++; if (instr_valid !== 1'b1 || instr !== w_00 || instr_pc !== 8'h00) begin n_fail++; $display("FAIL wrap_instr_00: got v%b %h @%h exp v1 %h @00", instr_valid, instr, instr_pc, w_00); end
    redirect = 1'b1; redirect_addr = 8'h10;
    @(negedge clk);
    redirect = 1'b0;
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rda_valid: got %b exp 0", instr_valid); end
    n_tests++; if (fetch_count !== (CNT_EN ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL rda_count: got %0d exp %0d", fetch_count, CNT_EN ? 1 : 0); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin n_fail++; $display("FAIL rda_addr: got req %b addr %h exp req 1 addr 10", imem_req, imem_addr); end
    instr_ack = 1'b0;
  endtask

  task automatic test_reset_midfetch;
    bit got = 1'b0;
    bit seen_req = 1'b0;
    int delivered = 0;
    mem_rand = 1'b0; mem_wait = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom | 32'h1;
    instr_ack = 1'b0;
    do_reset(8'h00, 1'b0);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (instr_valid) got = 1'b1;
    end
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL mid_first_timeout: got %b exp 1", got); end
    mem_wait = 5;
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL mid_rst_req: got req %b addr %h exp 0 00", imem_req, imem_addr); end
    n_tests++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 8'h00) begin n_fail++; $display("FAIL mid_rst_instr: got v%b %h @%h exp 0", instr_valid, instr, instr_pc); end
    n_tests++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL mid_rst_count: got %0d exp 0", fetch_count); end
    mem_wait = 0;
    instr_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 100 && delivered < 10; i++) begin
      @(negedge clk);
      if (imem_req && !seen_req) begin
        seen_req = 1'b1;
        n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL mid_first_addr: got %h exp 00", imem_addr); end
      end
      if (instr_valid) begin
        n_tests++; if (instr_pc !== 8'(delivered)) begin n_fail++; $display("FAIL mid_seq_pc: got %h exp %h", instr_pc, 8'(delivered)); end
        delivered++;
      end
    end
    @(negedge clk);
    instr_ack = 1'b0;
    @(negedge clk);
    n_tests++; if (delivered != 10) begin n_fail++; $display("FAIL mid_deliver_timeout: got %0d exp 10", delivered); end
    n_tests++; if (fetch_count !== (CNT_EN ? 32'd10 : 32'd0)) begin n_fail++; $display("FAIL mid_count10: got %0d exp %0d", fetch_count, CNT_EN ? 10 : 0); end
  endtask

  // Reference: delivered instructions form the sequence mem[p], mem[p+1], ...
  // and every redirect restarts the sequence at its target.
  task automatic test_random;
    logic [7:0] exp_pc = 8'h00;
    int unsigned model_cnt = 0;
    bit post_redirect = 1'b0;
    bit a, r;
    logic [7:0] ra;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem_rand = 1'b1;
    instr_ack = 1'b0;
    do_reset(8'h00, 1'b0);
    proto_err = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (post_redirect) begin
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_squash: cycle %0d got valid %b exp 0", i, instr_valid); end
      end
      post_redirect = 1'b0;
      a  = ($urandom_range(0, 9) < 6);
      r  = ($urandom_range(0, 99) < 8);
      ra = 8'($urandom);
      instr_ack = a; redirect = r; redirect_addr = ra;
      if (instr_valid && a && !r) begin
        n_tests++; if (instr_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc: cycle %0d got %h exp %h", i, instr_pc, exp_pc); end
        n_tests++; if (instr !== mem[exp_pc]) begin n_fail++; $display("FAIL rnd_instr: cycle %0d got %h exp %h", i, instr, mem[exp_pc]); end
        exp_pc = exp_pc + 8'd1;
        model_cnt++;
      end
      if (r) begin
        exp_pc = ra;
        post_redirect = 1'b1;
      end
    end
    instr_ack = 1'b0; redirect = 1'b0;
    @(negedge clk);
    n_tests++; if (model_cnt < 20) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries exp >= 20", model_cnt); end
    n_tests++; if (fetch_count !== (CNT_EN ? model_cnt : 32'd0)) begin n_fail++; $display("FAIL rnd_count: got %0d exp %0d", fetch_count, CNT_EN ? model_cnt : 0); end
    n_tests++; if (proto_err != 0) begin n_fail++; $display("FAIL rnd_addr_stable: got %0d violations exp 0", proto_err); end
    mem_rand = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset;
    test_zero_wait;
    test_latency_stall;
    test_redirect_drain;
    test_wrap_redirect_ack;
    test_reset_midfetch;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
